// File: rtl/mult_uart_sequencer.sv
// Frame sequencer between a byte UART and a multiplier core: collects header + X + Y bytes,
// launches one multiply, captures the product and streams it back MS byte first.
module mult_uart_sequencer #(
  parameter int         OPERAND_W   = 256,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000,
  parameter bit         AUTO_TX     = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_all,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic                     start_tx,
  output logic [OPERAND_W-1:0]     mul_X,
  output logic [OPERAND_W-1:0]     mul_Y,
  output logic                     mul_in_valid,
  input  logic [2*OPERAND_W-1:0]   mul_P,
  input  logic                     mul_out_valid,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     rx_overrun
);

  localparam int NB    = OPERAND_W / 8;
  localparam int CNT_W = $clog2(2 * NB + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] NB_CNT    = CNT_W'(NB);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2 * NB - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_OPS,
    S_LAUNCH,
    S_WAIT_P,
    S_HOLD,
    S_TX
  } state_t;

  state_t                   state_reg,      state_next;
  logic [CNT_W-1:0]         cnt_reg,        cnt_next;
  logic [TMR_W-1:0]         timer_reg,      timer_next;
  logic [OPERAND_W-1:0]     x_shift_reg,    x_shift_next;
  logic [OPERAND_W-1:0]     y_shift_reg,    y_shift_next;
  logic [OPERAND_W-1:0]     mul_x_reg,      mul_x_next;
  logic [OPERAND_W-1:0]     mul_y_reg,      mul_y_next;
  logic [2*OPERAND_W-1:0]   product_reg,    product_next;
  logic                     frame_done_reg, frame_done_next;
  logic                     frame_err_reg,  frame_err_next;
  logic                     overrun_reg,    overrun_next;

  always_ff @(posedge clock) begin
    if (!reset_all) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      timer_reg      <= '0;
      x_shift_reg    <= '0;
      y_shift_reg    <= '0;
      mul_x_reg      <= '0;
      mul_y_reg      <= '0;
      product_reg    <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      timer_reg      <= timer_next;
      x_shift_reg    <= x_shift_next;
      y_shift_reg    <= y_shift_next;
      mul_x_reg      <= mul_x_next;
      mul_y_reg      <= mul_y_next;
      product_reg    <= product_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    timer_next      = timer_reg;
    x_shift_next    = x_shift_reg;
    y_shift_next    = y_shift_reg;
    mul_x_next      = mul_x_reg;
    mul_y_next      = mul_y_reg;
    product_next    = product_reg;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;
    overrun_next    = overrun_reg;

    // Any byte arriving while the frame is being processed or returned is lost.
    if (rx_valid && state_reg != S_IDLE && state_reg != S_RX_OPS) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_next = S_RX_OPS;
          cnt_next   = '0;
          timer_next = '0;
        end
      end

      S_RX_OPS: begin
        if (rx_valid) begin
          timer_next = '0;
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg < NB_CNT) begin
            x_shift_next = {x_shift_reg[OPERAND_W-9:0], rx_data};
          end else begin
            y_shift_next = {y_shift_reg[OPERAND_W-9:0], rx_data};
          end
          // Operands become visible only once the whole frame has arrived.
          if (cnt_reg == LAST_BYTE) begin
            state_next = S_LAUNCH;
            mul_x_next = x_shift_reg;
            mul_y_next = {y_shift_reg[OPERAND_W-9:0], rx_data};
          end
        end else if (timer_reg == TMR_LAST) begin
          state_next     = S_IDLE;
          frame_err_next = 1'b1;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end

      S_LAUNCH: begin
        state_next = S_WAIT_P;
      end

      S_WAIT_P: begin
        if (mul_out_valid) begin
          product_next = mul_P;
          cnt_next     = '0;
          state_next   = AUTO_TX ? S_TX : S_HOLD;
        end
      end

      S_HOLD: begin
        if (start_tx) begin
          state_next = S_TX;
        end
      end

      S_TX: begin
        // The product is shifted so the byte on offer always sits in the top lane.
        if (tx_ready) begin
          product_next = {product_reg[2*OPERAND_W-9:0], 8'h00};
          if (cnt_reg == LAST_BYTE) begin
            state_next      = S_IDLE;
            frame_done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign tx_data      = product_reg[2*OPERAND_W-1 -: 8];
  assign tx_valid     = (state_reg == S_TX);
  assign mul_in_valid = (state_reg == S_LAUNCH);
  assign busy         = (state_reg != S_IDLE);
  assign mul_X        = mul_x_reg;
  assign mul_Y        = mul_y_reg;
  assign frame_done   = frame_done_reg;
  assign frame_err    = frame_err_reg;
  assign rx_overrun   = overrun_reg;

endmodule
